// File: rtl/cpu_pkg.sv
// Shared widths, opcodes and state encoding for the accumulator-machine controller.
package cpu_pkg;

    localparam int ADDR_W = 4;
    localparam int DATA_W = 8;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_LDA = 4'h1;
    localparam logic [3:0] OP_STA = 4'h2;
    localparam logic [3:0] OP_ADD = 4'h3;
    localparam logic [3:0] OP_SUB = 4'h4;
    localparam logic [3:0] OP_AND = 4'h5;
    localparam logic [3:0] OP_JMP = 4'h6;
    localparam logic [3:0] OP_JZ  = 4'h7;
    localparam logic [3:0] OP_HLT = 4'hF;

    typedef enum logic [2:0] {
        FETCH,
        LOAD_IR,
        EXECUTE,
        EXEC_READ,
        EXEC_ALU,
        HALT
    } state_t;

    // Opcodes that need a second memory read for their operand.
    function automatic logic needs_operand(input logic [3:0] op);
        return (op == OP_LDA) || (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND);
    endfunction

endpackage

// File: rtl/cpu_alu.sv
// Combinational ALU: load pass-through, add/sub with 9-bit carry/borrow, bitwise AND.
module cpu_alu
    import cpu_pkg::*;
(
    input  logic [DATA_W-1:0] acc,
    input  logic [DATA_W-1:0] operand,
    input  logic [3:0]        opcode,
    output logic [DATA_W-1:0] result,
    output logic              carry_out
);

    logic [DATA_W:0] wide;

    always_comb begin
        result    = acc;
        carry_out = 1'b0;
        wide      = '0;
        case (opcode)
            OP_LDA: result = operand;
            OP_ADD: begin
                wide      = {1'b0, acc} + {1'b0, operand};
                result    = wide[DATA_W-1:0];
                carry_out = wide[DATA_W];
            end
            OP_SUB: begin
                // bit 8 of the 9-bit difference is the borrow
                wide      = {1'b0, acc} - {1'b0, operand};
                result    = wide[DATA_W-1:0];
                carry_out = wide[DATA_W];
            end
            OP_AND: result = acc & operand;
            default: ;
        endcase
    end

endmodule

// File: rtl/fetch_exec_controller.sv
// Fetch/decode/execute control unit driving the single port of a 16x8 memory.
//
//   state     | meaning
//   ----------+-----------------------------------------------
//   FETCH     | read strobe at pc
//   LOAD_IR   | capture instruction, pc+1, pick execute path
//   EXECUTE   | STA write strobe, JMP/JZ pc update, HLT exit
//   EXEC_READ | read strobe at operand address
//   EXEC_ALU  | acc/carry update from read data
//   HALT      | parked until reset
module fetch_exec_controller
    import cpu_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    output logic              write_enable,
    output logic              read_enable,
    output logic [ADDR_W-1:0] address,
    output logic [DATA_W-1:0] data_out,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] acc,
    output logic [ADDR_W-1:0] pc,
    output logic              zero,
    output logic              carry,
    output logic              halted
);

    state_t            state, state_next;
    logic [DATA_W-1:0] ir;
    logic [3:0]        opcode;
    logic [ADDR_W-1:0] operand_addr;
    logic [DATA_W-1:0] alu_result;
    logic              alu_carry;

    assign opcode       = ir[7:4];
    assign operand_addr = ir[3:0];
    assign data_out     = acc;
    assign zero         = (acc == '0);
    assign halted       = (state == HALT);

    cpu_alu u_alu (
        .acc       (acc),
        .operand   (data_in),
        .opcode    (opcode),
        .result    (alu_result),
        .carry_out (alu_carry)
    );

    always_ff @(posedge clk) begin
        if (reset) state <= FETCH;
        else       state <= state_next;
    end

    always_comb begin
        state_next   = state;
        read_enable  = 1'b0;
        write_enable = 1'b0;
        address      = pc;
        case (state)
            FETCH: begin
                read_enable = 1'b1;
                state_next  = LOAD_IR;
            end
            // ir is not loaded yet, so decode the path from the incoming word
            LOAD_IR: state_next = needs_operand(data_in[7:4]) ? EXEC_READ : EXECUTE;
            EXECUTE: begin
                if (opcode == OP_STA) begin
                    write_enable = 1'b1;
                    address      = operand_addr;
                end
                state_next = (opcode == OP_HLT) ? HALT : FETCH;
            end
            EXEC_READ: begin
                read_enable = 1'b1;
                address     = operand_addr;
                state_next  = EXEC_ALU;
            end
            EXEC_ALU: state_next = FETCH;
            HALT:     state_next = HALT;
            default:  state_next = FETCH;
        endcase
        if (reset) begin
            read_enable  = 1'b0;
            write_enable = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc    <= '0;
            acc   <= '0;
            ir    <= '0;
            carry <= 1'b0;
        end else begin
            case (state)
                LOAD_IR: begin
                    ir <= data_in;
                    pc <= pc + ADDR_W'(1);
                end
                EXECUTE: begin
                    if ((opcode == OP_JMP) || ((opcode == OP_JZ) && zero))
                        pc <= operand_addr;
                end
                EXEC_ALU: begin
                    acc <= alu_result;
                    if ((opcode == OP_ADD) || (opcode == OP_SUB))
                        carry <= alu_carry;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_exec_controller.sv
// Directed program vectors, reset corner cases and random programs against an ISA-level model.
module tb_fetch_exec_controller;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       write_enable, read_enable;
    logic [3:0] address, pc;
    logic [7:0] data_out, data_in, acc;
    logic       zero, carry, halted;

    always #5 clk = ~clk;

    fetch_exec_controller dut (
        .clk          (clk),
        .reset        (reset),
        .write_enable (write_enable),
        .read_enable  (read_enable),
        .address      (address),
        .data_out     (data_out),
        .data_in      (data_in),
        .acc          (acc),
        .pc           (pc),
        .zero         (zero),
        .carry        (carry),
        .halted       (halted)
    );

    // 16x8 memory with registered read, plus a bulk-load port for the bench
    logic [7:0]       mem [16];
    logic [7:0]       mem_q = 8'h00;
    logic             load_en = 1'b0;
    logic [15:0][7:0] load_img = '0;

    always @(posedge clk) begin
        if (load_en) begin
            for (int i = 0; i < 16; i++) mem[i] <= load_img[i];
            mem_q <= 8'h00;
        end else begin
            if (write_enable) mem[address] <= data_out;
            if (read_enable)  mem_q <= mem[address];
        end
    end
    assign data_in = mem_q;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic apply_reset(input logic [15:0][7:0] img);
        @(negedge clk);
        reset = 1'b1; load_en = 1'b1; load_img = img;
        #1;
        chk("rst_re", int'(read_enable), 0);
        chk("rst_we", int'(write_enable), 0);
        @(negedge clk);
        load_en = 1'b0;
        #1;
        chk("rst_pc", int'(pc), 0);
        chk("rst_acc", int'(acc), 0);
        chk("rst_halted", int'(halted), 0);
        chk("rst_re2", int'(read_enable), 0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("post_rst_re", int'(read_enable), 1);
        chk("post_rst_addr", int'(address), 0);
    endtask

    // Advance n cycles, watching the strobes; ends at negedge+1.
    int         we_cnt, overlap, halt_early;
    logic [3:0] we_addr;
    logic [7:0] we_data;

    task automatic run_cycles(input int n);
        we_cnt = 0; overlap = 0; halt_early = 0; we_addr = 4'h0; we_data = 8'h00;
        for (int i = 0; i < n; i++) begin
            if (write_enable) begin
                we_cnt++;
                we_addr = address;
                we_data = data_out;
            end
            if (write_enable && read_enable) overlap++;
            if (halted) halt_early++;
            @(negedge clk);
            #1;
        end
    endtask

    typedef struct {
        logic [15:0][7:0] img;
        int               cycles;
        logic [7:0]       e_acc;
        logic             e_carry;
        logic [3:0]       e_pc;
        logic             e_halt;
        int               e_we;
        logic [3:0]       m_addr;
        logic [7:0]       m_val;
    } vec_t;

    vec_t vecs[7];

    // ISA-level reference model
    logic [7:0] m_mem [16];
    int         m_acc, m_carry, m_pc, m_halt, m_cyc, m_we;

    task automatic model_step();
        int ins, op, a, t;
        ins = int'(m_mem[m_pc]);
        op  = ins / 16;
        a   = ins % 16;
        m_pc = (m_pc + 1) % 16;
        m_cyc = 3;
        m_we  = 0;
        case (op)
            1: begin m_acc = int'(m_mem[a]); m_cyc = 4; end
            2: begin m_mem[a] = 8'(m_acc); m_we = 1; end
            3: begin t = m_acc + int'(m_mem[a]); m_carry = (t > 255) ? 1 : 0; m_acc = t % 256; m_cyc = 4; end
            4: begin t = m_acc - int'(m_mem[a]); m_carry = (t < 0) ? 1 : 0; m_acc = (t + 256) % 256; m_cyc = 4; end
            5: begin m_acc = int'(8'(m_acc) & m_mem[a]); m_cyc = 4; end
            6: m_pc = a;
            7: if (m_acc == 0) m_pc = a;
            15: m_halt = 1;
            default: ;
        endcase
    endtask

    initial begin
        logic [15:0][7:0] img;

        for (int k = 0; k < 7; k++) vecs[k].img = '0;
        // program from the plan: 5 + 3 stored to M14
        vecs[0].img[0] = 8'h1A; vecs[0].img[1] = 8'h3B; vecs[0].img[2] = 8'h2E; vecs[0].img[3] = 8'hF0;
        vecs[0].img[10] = 8'h05; vecs[0].img[11] = 8'h03;
        vecs[0].cycles = 14; vecs[0].e_acc = 8'h08; vecs[0].e_carry = 0; vecs[0].e_pc = 4'd4;
        vecs[0].e_halt = 1; vecs[0].e_we = 1; vecs[0].m_addr = 4'd14; vecs[0].m_val = 8'h08;
        // FF + 01 -> 0 with carry, JZ 9 taken, HLT at 9
        vecs[1].img[0] = 8'h1A; vecs[1].img[1] = 8'h3B; vecs[1].img[2] = 8'h79; vecs[1].img[9] = 8'hF0;
        vecs[1].img[10] = 8'hFF; vecs[1].img[11] = 8'h01;
        vecs[1].cycles = 14; vecs[1].e_acc = 8'h00; vecs[1].e_carry = 1; vecs[1].e_pc = 4'd10;
        vecs[1].e_halt = 1; vecs[1].e_we = 0; vecs[1].m_addr = 4'd10; vecs[1].m_val = 8'hFF;
        // JZ not taken with acc=1
        vecs[2].img[0] = 8'h1A; vecs[2].img[1] = 8'h79; vecs[2].img[2] = 8'hF0; vecs[2].img[9] = 8'hF0;
        vecs[2].img[10] = 8'h01;
        vecs[2].cycles = 10; vecs[2].e_acc = 8'h01; vecs[2].e_carry = 0; vecs[2].e_pc = 4'd3;
        vecs[2].e_halt = 1; vecs[2].e_we = 0; vecs[2].m_addr = 4'd10; vecs[2].m_val = 8'h01;
        // 2 - 5 borrows
        vecs[3].img[0] = 8'h1A; vecs[3].img[1] = 8'h4B; vecs[3].img[2] = 8'hF0;
        vecs[3].img[10] = 8'h02; vecs[3].img[11] = 8'h05;
        vecs[3].cycles = 11; vecs[3].e_acc = 8'hFD; vecs[3].e_carry = 1; vecs[3].e_pc = 4'd3;
        vecs[3].e_halt = 1; vecs[3].e_we = 0; vecs[3].m_addr = 4'd11; vecs[3].m_val = 8'h05;
        // JMP 15, undefined opcode at 15, pc wraps to 0
        vecs[4].img[0] = 8'h1A; vecs[4].img[1] = 8'h6F; vecs[4].img[15] = 8'h80; vecs[4].img[10] = 8'h5A;
        vecs[4].cycles = 10; vecs[4].e_acc = 8'h5A; vecs[4].e_carry = 0; vecs[4].e_pc = 4'd0;
        vecs[4].e_halt = 0; vecs[4].e_we = 0; vecs[4].m_addr = 4'd15; vecs[4].m_val = 8'h80;
        // FF + FF sets carry, AND keeps it
        vecs[5].img[0] = 8'h1A; vecs[5].img[1] = 8'h3C; vecs[5].img[2] = 8'h5B; vecs[5].img[3] = 8'hF0;
        vecs[5].img[10] = 8'hFF; vecs[5].img[11] = 8'h0F; vecs[5].img[12] = 8'hFF;
        vecs[5].cycles = 15; vecs[5].e_acc = 8'h0E; vecs[5].e_carry = 1; vecs[5].e_pc = 4'd4;
        vecs[5].e_halt = 1; vecs[5].e_we = 0; vecs[5].m_addr = 4'd12; vecs[5].m_val = 8'hFF;
        // undefined opcode 9, STA 13, NOP
        vecs[6].img[0] = 8'h1A; vecs[6].img[1] = 8'h95; vecs[6].img[2] = 8'h2D; vecs[6].img[3] = 8'h00;
        vecs[6].img[4] = 8'hF0; vecs[6].img[10] = 8'h77;
        vecs[6].cycles = 16; vecs[6].e_acc = 8'h77; vecs[6].e_carry = 0; vecs[6].e_pc = 4'd5;
        vecs[6].e_halt = 1; vecs[6].e_we = 1; vecs[6].m_addr = 4'd13; vecs[6].m_val = 8'h77;

        for (int k = 0; k < 7; k++) begin
            apply_reset(vecs[k].img);
            run_cycles(vecs[k].cycles);
            chk($sformatf("v%0d_acc", k), int'(acc), int'(vecs[k].e_acc));
            chk($sformatf("v%0d_carry", k), int'(carry), int'(vecs[k].e_carry));
            chk($sformatf("v%0d_zero", k), int'(zero), (vecs[k].e_acc == 8'h00) ? 1 : 0);
            chk($sformatf("v%0d_pc", k), int'(pc), int'(vecs[k].e_pc));
            chk($sformatf("v%0d_halted", k), int'(halted), int'(vecs[k].e_halt));
            chk($sformatf("v%0d_halt_early", k), halt_early, 0);
            chk($sformatf("v%0d_we_cnt", k), we_cnt, vecs[k].e_we);
            chk($sformatf("v%0d_overlap", k), overlap, 0);
            chk($sformatf("v%0d_mem", k), int'(mem[vecs[k].m_addr]), int'(vecs[k].m_val));
            if (vecs[k].e_we == 1) begin
                chk($sformatf("v%0d_we_addr", k), int'(we_addr), int'(vecs[k].m_addr));
                chk($sformatf("v%0d_we_data", k), int'(we_data), int'(vecs[k].m_val));
            end
            if (vecs[k].e_halt == 1'b0) begin
                chk($sformatf("v%0d_fetch_re", k), int'(read_enable), 1);
                chk($sformatf("v%0d_fetch_addr", k), int'(address), int'(vecs[k].e_pc));
            end
        end

        // reset while the LDA operand read is in flight
        img = '0; img[0] = 8'h1A; img[10] = 8'h33;
        apply_reset(img);
        @(negedge clk); #1;
        @(negedge clk); #1;
        chk("rr_read_re", int'(read_enable), 1);
        chk("rr_read_addr", int'(address), 10);
        reset = 1'b1;
        #1;
        chk("rr_gate_re", int'(read_enable), 0);
        chk("rr_gate_we", int'(write_enable), 0);
        @(negedge clk); #1;
        chk("rr_acc", int'(acc), 0);
        chk("rr_pc", int'(pc), 0);
        reset = 1'b0;
        #1;
        chk("rr_refetch_re", int'(read_enable), 1);
        chk("rr_refetch_addr", int'(address), 0);
        run_cycles(4);
        chk("rr_rerun_acc", int'(acc), 8'h33);

        // random programs against the ISA model, compared at every instruction boundary
        for (int it = 0; it < 20; it++) begin
            for (int i = 0; i < 16; i++) img[i] = 8'($urandom);
            apply_reset(img);
            for (int i = 0; i < 16; i++) m_mem[i] = img[i];
            m_acc = 0; m_carry = 0; m_pc = 0; m_halt = 0;
            for (int n = 0; n < 40 && m_halt == 0; n++) begin
                model_step();
                run_cycles(m_cyc);
                chk($sformatf("r%0d_%0d_acc", it, n), int'(acc), m_acc);
                chk($sformatf("r%0d_%0d_carry", it, n), int'(carry), m_carry);
                chk($sformatf("r%0d_%0d_zero", it, n), int'(zero), (m_acc == 0) ? 1 : 0);
                chk($sformatf("r%0d_%0d_pc", it, n), int'(pc), m_pc);
                chk($sformatf("r%0d_%0d_halted", it, n), int'(halted), m_halt);
                chk($sformatf("r%0d_%0d_we", it, n), we_cnt, m_we);
                chk($sformatf("r%0d_%0d_re", it, n), int'(read_enable), 1 - m_halt);
            end
            for (int i = 0; i < 16; i++)
                chk($sformatf("r%0d_mem%0d", it, i), int'(mem[i]), int'(m_mem[i]));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
